// File: rtl/pi_ctl_slew.sv
// pi_ctl_slew: slew-rate limiter from the MM CDR loop filter PI code target
// to the phase interpolator lanes. Optional stats: `define PI_SLEW_STATS_EN.
//
// Ports:
//   clk          core clock
//   ext_rst      asynchronous active-high reset
//   target_code  PI code requested by the CDR (Npi bits)
//   target_valid capture target_code this cycle
//   en_slew      1 = slew-limit toward the target, 0 = bypass
//   max_step     largest code change per update tick (0 = freeze)
//   upd_div      an update tick occurs every upd_div+1 cycles while slewing
//   stats_clr    (PI_SLEW_STATS_EN only) clear clamp_count
//   pi_ctl       Nout lanes of Npi bits, all carrying the applied code
//   settled      applied code equals captured target, not slewing
//   slewing      slew in progress
//   clamp_count  (PI_SLEW_STATS_EN only) saturating count of clamped ticks
module pi_ctl_slew #(
    parameter int Npi        = 9,
    parameter int Nout       = 4,
    parameter int step_width = 4,
    parameter int div_width  = 8
) (
    input  logic                   clk,
    input  logic                   ext_rst,
    input  logic [Npi-1:0]         target_code,
    input  logic                   target_valid,
    input  logic                   en_slew,
    input  logic [step_width-1:0]  max_step,
    input  logic [div_width-1:0]   upd_div,
`ifdef PI_SLEW_STATS_EN
    input  logic                   stats_clr,
    output logic [15:0]            clamp_count,
`endif
    output logic [Nout*Npi-1:0]    pi_ctl,
    output logic                   settled,
    output logic                   slewing
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SLEW   = 2'd1,
        BYPASS = 2'd2
    } state_t;

    localparam logic [Npi:0] ONE_W = (Npi+1)'(1);

    state_t               state;
    state_t               state_nxt;
    logic [Npi-1:0]       target_q;
    logic [Npi-1:0]       target_nxt;
    logic [Npi-1:0]       cur;
    logic [Npi-1:0]       cur_nxt;
    logic [div_width-1:0] div_cnt;
    logic [div_width-1:0] div_nxt;

    logic [Npi-1:0]       diff;
    logic [Npi:0]         mag;
    logic [Npi:0]         step_ext;
    logic [Npi-1:0]       step_pi;
    logic [Npi-1:0]       step_cur;
    logic                 step_up;
    logic                 clamp;
    logic                 tick;
    logic                 do_step;

    assign target_nxt = target_valid ? target_code : target_q;

    // >= so that lowering upd_div mid-count ticks at once
    assign tick = (div_cnt >= upd_div);

    // diff is the signed shortest-path distance around the code circle
    assign diff = target_q - cur;

    // magnitude needs one extra bit to hold 2**(Npi-1)
    assign mag = diff[Npi-1] ? ({1'b0, ~diff} + ONE_W)
                             : {1'b0, diff};

    assign step_ext = (Npi+1)'(max_step);
    assign step_pi  = Npi'(max_step);
    assign clamp    = (mag > step_ext);

    // half-way tie (sign set, rest zero) resolves in the positive direction
    assign step_up = ~diff[Npi-1] || (diff[Npi-2:0] == '0);

    always_comb begin
        step_cur = target_q;
        if (clamp) begin
            if (step_up) begin
                step_cur = cur + step_pi;
            end else begin
                step_cur = cur - step_pi;
            end
        end
    end

    assign do_step = (state == SLEW) && en_slew && tick;

    // state register
    always_ff @(posedge clk or posedge ext_rst) begin
        if (ext_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (!en_slew) begin
                    state_nxt = BYPASS;
                end else if (target_q != cur) begin
                    state_nxt = SLEW;
                end
            end
            SLEW: begin
                if (!en_slew) begin
                    state_nxt = BYPASS;
                end else if (tick && (step_cur == target_q)) begin
                    state_nxt = IDLE;
                end
            end
            BYPASS: begin
                if (en_slew) begin
                    state_nxt = (cur == target_q) ? IDLE : SLEW;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // datapath next values
    always_comb begin
        cur_nxt = cur;
        div_nxt = '0;
        unique case (state)
            SLEW: begin
                if (en_slew) begin
                    if (tick) begin
                        cur_nxt = step_cur;
                    end else begin
                        div_nxt = div_cnt + 1'b1;
                    end
                end
            end
            BYPASS: begin
                cur_nxt = target_q;
            end
            default: begin
                cur_nxt = cur;
            end
        endcase
    end

    always_ff @(posedge clk or posedge ext_rst) begin
        if (ext_rst) begin
            target_q <= '0;
            cur      <= '0;
            div_cnt  <= '0;
            settled  <= 1'b1;
            slewing  <= 1'b0;
        end else begin
            target_q <= target_nxt;
            cur      <= cur_nxt;
            div_cnt  <= div_nxt;
            settled  <= (state_nxt != SLEW) && (cur_nxt == target_nxt);
            slewing  <= (state_nxt == SLEW);
        end
    end

    // all lanes carry the same code
    assign pi_ctl = {Nout{cur}};

`ifdef PI_SLEW_STATS_EN
    always_ff @(posedge clk or posedge ext_rst) begin
        if (ext_rst) begin
            clamp_count <= '0;
        end else if (stats_clr) begin
            clamp_count <= '0;
        end else if (do_step && clamp && (clamp_count != 16'hFFFF)) begin
            clamp_count <= clamp_count + 16'd1;
        end
    end
`endif

endmodule
